imem_responder: RTL

//   Instruction memory serving the fetch stage: accepts the fetch address and returns the

---
 rtl/imem_responder_if.sv | 28 ++
 rtl/imem_responder.sv | 108 ++++++++++
 2 files changed

// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch/loader bus of the instruction memory
// master = host loader plus fetch stage, slave = imem_responder.
interface imem_responder_if #(
  parameter int WORD = 32,
  parameter int ADDR = 16
);
  logic [ADDR-1:0] addr_i;
  logic [WORD-1:0] inst_o;
  logic            stall_i;
  logic            stall_o;
  logic            ld_v_i;
  logic [WORD-1:0] ld_data_i;
  logic            ld_last_i;
  logic            ld_rdy_o;
  logic            reload_i;
  logic            run_o;
  logic            err_o;

  modport master (
    output addr_i, stall_i, ld_v_i, ld_data_i, ld_last_i, reload_i,
    input  inst_o, stall_o, ld_rdy_o, run_o, err_o
  );

  modport slave (
    input  addr_i, stall_i, ld_v_i, ld_data_i, ld_last_i, reload_i,
    output inst_o, stall_o, ld_rdy_o, run_o, err_o
  );
endinterface

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - loader-filled instruction memory with 1-cycle fetch reads
// Optional per-word even parity with sticky err_o when IMEM_PARITY_EN is defined.
module imem_responder #(
  parameter int              WORD       = 32,
  parameter int              ADDR       = 16,
  parameter int              DEPTH_LOG2 = 10,
  parameter logic [WORD-1:0] NOP        = '0
) (
  input logic               clk,
  input logic               rst,
  imem_responder_if.slave   bus
);
  localparam int                    DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [ADDR:0]         DEPTH_A = (ADDR + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;

  typedef enum logic {LOAD, RUN} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic [WORD-1:0]       inst_q, inst_d;
  logic                  err_q, err_d;

  logic [WORD-1:0]       mem [DEPTH];
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] rd_idx;
  logic [WORD-1:0]       rd_word;
  logic                  in_range;
  logic                  rd_bad;

  // Full-width compare so addresses beyond DEPTH never alias into the array.
  assign rd_idx   = bus.addr_i[DEPTH_LOG2-1:0];
  assign in_range = {1'b0, bus.addr_i} < DEPTH_A;
  assign rd_word  = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) mem[ptr_q] <= bus.ld_data_i;
  end

`ifdef IMEM_PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) par[ptr_q] <= ^bus.ld_data_i;
  end

  assign rd_bad    = (^rd_word) != par[rd_idx];
  assign bus.err_o = err_q;
`else
  assign rd_bad    = 1'b0;
  assign bus.err_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    inst_d  = inst_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    case (state_q)
      LOAD: begin
        inst_d = NOP;
        if (bus.ld_v_i) begin
          wr_en = 1'b1;
          if (bus.ld_last_i || ptr_q == PTR_MAX) state_d = RUN;
          // Pointer parks at the last slot instead of wrapping.
          if (ptr_q != PTR_MAX) ptr_d = ptr_q + 1'b1;
        end
      end
      RUN: begin
        if (bus.reload_i) begin
          state_d = LOAD;
          ptr_d   = '0;
          inst_d  = NOP;
          err_d   = 1'b0;
        end else if (!bus.stall_i) begin
          if (!in_range) begin
            inst_d = NOP;
          end else if (rd_bad) begin
            inst_d = NOP;
            err_d  = 1'b1;
          end else begin
            inst_d = rd_word;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      inst_q  <= NOP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  assign bus.inst_o   = inst_q;
  assign bus.stall_o  = (state_q == LOAD);
  assign bus.ld_rdy_o = (state_q == LOAD);
  assign bus.run_o    = (state_q == RUN);
endmodule
